key_debounce: RTL

Per-key conditioning stage that sits directly upstream of the mode/control logic and the picture navigation logic on the 5x7 LED-matrix board. It takes the seven raw push-button inputs and synchronises them to `CLOCK_50`. It then debounces each key with a shared millisecond tick and emits a clean level plus single-cycle press, release and auto-repeat strobes. Downstream blocks consume the strobes instead of sampling `keys` directly.

---
 rtl/key_debounce.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, tick-based debouncer and auto-repeat strobe generator

module key_debounce #(
    parameter int N_KEYS     = 7,
    parameter int TICK_DIV   = 50000,
    parameter int DEB_MS     = 20,
    parameter int HOLD_MS    = 500,
    parameter int RPT_MS     = 100,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0]      DEB_LIM   = 8'(DEB_MS);
    localparam logic [11:0]     HOLD_LIM  = 12'(HOLD_MS);
    localparam logic [11:0]     RPT_LIM   = 12'(RPT_MS);
    localparam logic [N_KEYS-1:0] IDLE_RAW = {N_KEYS{ACTIVE_LOW}};

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        REPEATING  = 1'b1
    } rpt_state_t;

    logic [PW-1:0]             presc;
    logic                      tick;
    logic [N_KEYS-1:0]         sync1;
    logic [N_KEYS-1:0]         sync2;
    logic [N_KEYS-1:0]         raw_p;

    logic [N_KEYS-1:0][7:0]    deb_cnt;
    logic [N_KEYS-1:0][7:0]    deb_cnt_nx;
    logic [N_KEYS-1:0][11:0]   hold_cnt;
    logic [N_KEYS-1:0][11:0]   hold_cnt_nx;
    rpt_state_t                rpt_state    [N_KEYS];
    rpt_state_t                rpt_state_nx [N_KEYS];

    logic [N_KEYS-1:0]         level_nx;
    logic [N_KEYS-1:0]         press_nx;
    logic [N_KEYS-1:0]         release_nx;
    logic [N_KEYS-1:0]         repeat_nx;

    // Shared debounce/repeat timebase.
    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Synchroniser idles at the released level so a key held through reset is re-debounced.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    assign raw_p = ACTIVE_LOW ? ~sync2 : sync2;

    always_comb begin
        level_nx   = key_level;
        press_nx   = '0;
        release_nx = '0;
        repeat_nx  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            deb_cnt_nx[i]   = deb_cnt[i];
            hold_cnt_nx[i]  = hold_cnt[i];
            rpt_state_nx[i] = rpt_state[i];

            if (raw_p[i] == key_level[i]) begin
                deb_cnt_nx[i] = '0;
            end else if (tick) begin
                if (deb_cnt[i] + 8'd1 == DEB_LIM) begin
                    deb_cnt_nx[i] = '0;
                    level_nx[i]   = ~key_level[i];
                    press_nx[i]   = ~key_level[i];
                    release_nx[i] = key_level[i];
                end else begin
                    deb_cnt_nx[i] = deb_cnt[i] + 8'd1;
                end
            end

            // A release on this edge wins over any repeat that would have fired.
            if (!key_level[i] || release_nx[i]) begin
                hold_cnt_nx[i]  = '0;
                rpt_state_nx[i] = WAIT_FIRST;
            end else if (tick) begin
                unique case (rpt_state[i])
                    WAIT_FIRST: begin
                        if (hold_cnt[i] + 12'd1 == HOLD_LIM) begin
                            repeat_nx[i]    = 1'b1;
                            hold_cnt_nx[i]  = '0;
                            rpt_state_nx[i] = REPEATING;
                        end else begin
                            hold_cnt_nx[i] = hold_cnt[i] + 12'd1;
                        end
                    end
                    REPEATING: begin
                        if (hold_cnt[i] + 12'd1 == RPT_LIM) begin
                            repeat_nx[i]   = 1'b1;
                            hold_cnt_nx[i] = '0;
                        end else begin
                            hold_cnt_nx[i] = hold_cnt[i] + 12'd1;
                        end
                    end
                    default: begin
                        hold_cnt_nx[i]  = '0;
                        rpt_state_nx[i] = WAIT_FIRST;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_repeat  <= '0;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                rpt_state[i] <= WAIT_FIRST;
            end
        end else begin
            key_level   <= level_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
            key_repeat  <= repeat_nx;
            deb_cnt     <= deb_cnt_nx;
            hold_cnt    <= hold_cnt_nx;
            for (int i = 0; i < N_KEYS; i++) begin
                rpt_state[i] <= rpt_state_nx[i];
            end
        end
    end

endmodule
